// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: assembles opcode + payload byte frames into one command.
// Ports: CLK, RST (sync, active low), RX_P_Data/RX_D_VLD byte stream in,
//        CMD_RDY in; CMD_VLD + CMD_TYPE/ADDR/WDATA/OP_A/OP_B/FUN command out,
//        CMD_BAD_OP/CMD_TIMEOUT/CMD_DROP one-cycle event pulses.
module cmd_frame_parser #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          ADDR_WIDTH     = 4,
    parameter int          FUN_WIDTH      = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_Data,
    input  logic                  RX_D_VLD,
    input  logic                  CMD_RDY,
    output logic                  CMD_VLD,
    output logic [1:0]            CMD_TYPE,
    output logic [ADDR_WIDTH-1:0] CMD_ADDR,
    output logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic [DATA_WIDTH-1:0] CMD_OP_A,
    output logic [DATA_WIDTH-1:0] CMD_OP_B,
    output logic [FUN_WIDTH-1:0]  CMD_FUN,
    output logic                  CMD_BAD_OP,
    output logic                  CMD_TIMEOUT,
    output logic                  CMD_DROP
);

    localparam logic [DATA_WIDTH-1:0] OP_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_FN  = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, HOLD
    } state_t;

    state_t                  state, next_state, op_state;
    logic [15:0]             cnt, cnt_d;
    logic                    op_take, op_known, in_get, to_hit;
    logic [1:0]              op_type, type_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d, opa_d, opb_d;
    logic [FUN_WIDTH-1:0]    fun_d;
    logic                    vld_d, bad_d, to_d, drop_d;

    // Opcode lookup, shared by IDLE and the HOLD+RDY overlap case.
    always_comb begin
        op_known = 1'b1;
        op_type  = 2'b00;
        op_state = IDLE;
        case (RX_P_Data)
            OP_WR:   begin op_type = 2'b00; op_state = GET_ADDR; end
            OP_RD:   begin op_type = 2'b01; op_state = GET_ADDR; end
            OP_ALU:  begin op_type = 2'b10; op_state = GET_OPA;  end
            OP_FN:   begin op_type = 2'b11; op_state = GET_FUN;  end
            default: op_known = 1'b0;
        endcase
    end

    assign op_take = RX_D_VLD &&
                     (state == IDLE || (state == HOLD && CMD_RDY));
    assign in_get  = state inside {GET_ADDR, GET_DATA, GET_OPA,
                                   GET_OPB, GET_FUN};
    // A byte in the limit cycle wins over the timeout.
    assign to_hit  = in_get && !RX_D_VLD &&
                     (TIMEOUT_CYCLES != 16'd0) &&
                     (cnt == TIMEOUT_CYCLES - 16'd1);

    // State register and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            CMD_VLD     <= 1'b0;
            CMD_TYPE    <= '0;
            CMD_ADDR    <= '0;
            CMD_WDATA   <= '0;
            CMD_OP_A    <= '0;
            CMD_OP_B    <= '0;
            CMD_FUN     <= '0;
            CMD_BAD_OP  <= 1'b0;
            CMD_TIMEOUT <= 1'b0;
            CMD_DROP    <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_d;
            CMD_VLD     <= vld_d;
            CMD_TYPE    <= type_d;
            CMD_ADDR    <= addr_d;
            CMD_WDATA   <= wdata_d;
            CMD_OP_A    <= opa_d;
            CMD_OP_B    <= opb_d;
            CMD_FUN     <= fun_d;
            CMD_BAD_OP  <= bad_d;
            CMD_TIMEOUT <= to_d;
            CMD_DROP    <= drop_d;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (op_take && op_known) next_state = op_state;
            GET_ADDR: if (RX_D_VLD)
                          next_state = (CMD_TYPE == 2'b00) ? GET_DATA : HOLD;
            GET_DATA: if (RX_D_VLD) next_state = HOLD;
            GET_OPA:  if (RX_D_VLD) next_state = GET_OPB;
            GET_OPB:  if (RX_D_VLD) next_state = GET_FUN;
            GET_FUN:  if (RX_D_VLD) next_state = HOLD;
            HOLD:     if (CMD_RDY)
                          next_state = (op_take && op_known) ? op_state : IDLE;
            default:  next_state = IDLE;
        endcase
        if (to_hit) next_state = IDLE;
    end

    // Output / datapath next values.
    always_comb begin
        type_d  = CMD_TYPE;
        addr_d  = CMD_ADDR;
        wdata_d = CMD_WDATA;
        opa_d   = CMD_OP_A;
        opb_d   = CMD_OP_B;
        fun_d   = CMD_FUN;
        if (op_take && op_known) type_d = op_type;
        if (RX_D_VLD) begin
            if (state == GET_ADDR) addr_d  = RX_P_Data[ADDR_WIDTH-1:0];
            if (state == GET_DATA) wdata_d = RX_P_Data;
            if (state == GET_OPA)  opa_d   = RX_P_Data;
            if (state == GET_OPB)  opb_d   = RX_P_Data;
            if (state == GET_FUN)  fun_d   = RX_P_Data[FUN_WIDTH-1:0];
        end
        vld_d  = (next_state == HOLD);
        bad_d  = op_take && !op_known;
        drop_d = RX_D_VLD && (state == HOLD) && !CMD_RDY;
        to_d   = to_hit;
        cnt_d  = (in_get && !RX_D_VLD && !to_hit) ? cnt + 16'd1 : 16'd0;
    end

endmodule

// File: doc/cmd_frame_parser.md
# cmd_frame_parser

Byte-to-command framer in the REF_CLK domain. It sits between the RX data synchronizer and the system controller. It consumes the synchronized UART receive stream (one byte per valid pulse) and assembles the multi-byte command frames into one decoded command. The decoded command is presented to the controller over a valid/ready handshake, so the controller handles whole commands instead of tracking byte positions.

## Interface
Parameters:
- DATA_WIDTH, 8, receive byte width
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function code width
- TIMEOUT_CYCLES, 16'd4096, number of idle CLK cycles allowed between bytes inside a frame; 0 disables the timeout

Ports:
- CLK  in  1  system reference clock; the block uses a single clock
- RST  in  1  synchronous, active-low reset
- RX_P_Data  in  DATA_WIDTH  synchronized received byte
- RX_D_VLD  in  1  single-cycle pulse; RX_P_Data is valid in that cycle
- CMD_RDY  in  1  controller accepts the command
- CMD_VLD  out  1  decoded command available
- CMD_TYPE  out  2  command type: 00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands
- CMD_ADDR  out  ADDR_WIDTH  register-file address
- CMD_WDATA  out  DATA_WIDTH  register-file write data
- CMD_OP_A  out  DATA_WIDTH  ALU operand A
- CMD_OP_B  out  DATA_WIDTH  ALU operand B
- CMD_FUN  out  FUN_WIDTH  ALU function code
- CMD_BAD_OP  out  1  one-cycle pulse when an unknown opcode byte arrives
- CMD_TIMEOUT  out  1  one-cycle pulse when a partial frame is aborted
- CMD_DROP  out  1  one-cycle pulse when a byte is discarded while a command is held

## Operation
- Frames are an opcode byte followed by payload bytes:
  - 0xAA: address, data
  - 0xBB: address
  - 0xCC: operand A, operand B, function
  - 0xDD: function
- FSM states: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN, HOLD.
- IDLE, on RX_D_VLD:
  - 0xAA: CMD_TYPE=00, go to GET_ADDR.
  - 0xBB: CMD_TYPE=01, go to GET_ADDR.
  - 0xCC: CMD_TYPE=10, go to GET_OPA.
  - 0xDD: CMD_TYPE=11, go to GET_FUN.
  - Any other byte: pulse CMD_BAD_OP and stay in IDLE.
- GET_ADDR: CMD_ADDR <= byte[ADDR_WIDTH-1:0]; the upper bits are ignored. Type 00 goes to GET_DATA; type 01 goes to HOLD.
- GET_DATA: CMD_WDATA <= byte, go to HOLD.
- GET_OPA: CMD_OP_A <= byte, go to GET_OPB.
- GET_OPB: CMD_OP_B <= byte, go to GET_FUN.
- GET_FUN: CMD_FUN <= byte[FUN_WIDTH-1:0], go to HOLD.
- HOLD: CMD_VLD=1.
  - With CMD_RDY=1 the handshake completes in that cycle, and the next state is IDLE.
  - With CMD_RDY=1 and RX_D_VLD=1 in the same cycle, the byte is decoded as an IDLE-state opcode, with the same transitions and the same CMD_BAD_OP rule.
  - With RX_D_VLD=1 and CMD_RDY=0, the byte is discarded, CMD_DROP pulses, and the state stays HOLD.
- Fields not written by a frame keep their previous values. CMD_OP_A and CMD_OP_B for type 11 are don't-care for the consumer.
- Timeout counter (16-bit):
  - Clears on every accepted byte and in IDLE and HOLD.
  - Increments each cycle in GET_* states without RX_D_VLD.
  - On reaching TIMEOUT_CYCLES: CMD_TIMEOUT pulses, state goes to IDLE, and the partial frame is discarded. CMD_VLD never asserts for that frame.
  - If the timeout limit and RX_D_VLD coincide, the byte wins: it is accepted, the counter clears, and there is no timeout pulse.

## Timing
- All outputs are registered.
- Reset (RST=0 at a CLK edge): state IDLE, counter 0, and every output 0.
- Reset mid-frame or in HOLD discards the command. CMD_VLD is 0 from the first edge with RST=0.
- CMD_VLD rises on the CLK edge that samples the final payload byte's RX_D_VLD, so it is visible one cycle after that pulse.
- While CMD_VLD=1 and CMD_RDY=0, all CMD_* fields are stable.
- CMD_VLD falls the cycle after CMD_RDY is sampled high, unless the same-cycle byte was an opcode; it then stays low until that frame completes.
- Minimum frame-to-command latency equals the frame byte count. Back-to-back RX_D_VLD pulses on consecutive cycles are supported.
- CMD_BAD_OP, CMD_TIMEOUT and CMD_DROP assert for exactly one cycle, in the cycle after the causing event.

## Test plan
- Write frame: AA,05,3C, CMD_RDY=1 → one-cycle CMD_VLD with TYPE=00, ADDR=5, WDATA=0x3C; then IDLE.
- Read and ALU frames:
  - BB,F2 → TYPE=01, ADDR=2 (upper bits ignored).
  - CC,07,03,01 → TYPE=10, OP_A=7, OP_B=3, FUN=1.
  - DD,0A → TYPE=11, FUN=0xA.
- Stall and handshake overlap:
  - Hold CMD_RDY=0 for 10 cycles after AA,01,55; send byte 0x12 during the stall → CMD_DROP pulse, fields stable.
  - Raise CMD_RDY in the same cycle as byte BB → new read frame starts; the next byte 03 yields ADDR=3.
- Bad opcode: byte 0x42 in IDLE → one CMD_BAD_OP pulse, no CMD_VLD; a following DD,02 decodes correctly.
- Timeout with TIMEOUT_CYCLES=20:
  - CC,01 then silence → CMD_TIMEOUT exactly 20 cycles after the last byte, state IDLE.
  - A byte arriving on cycle 20 is accepted instead, with no timeout pulse.
- Reset mid-frame: AA,04, then RST low one cycle, then 05 → CMD_BAD_OP pulse, no CMD_VLD, all outputs 0 during reset.
